// File: rtl/stream_counter.sv
// Programmable count sequencer: emits start, start+step, ... below an exclusive bound
// on a valid/read handshake, in one-shot or wrap mode, with a saturating transfer tally.
module stream_counter #(
  parameter int WIDTH   = 64,
  parameter int TALLY_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   start_val_in,
  input  logic [WIDTH-1:0]   end_val_in,
  input  logic [WIDTH-1:0]   step_in,
  input  logic               wrap_in,
  input  logic               start_in,
  input  logic               abort_in,
  input  logic               read_in,
  output logic               valid_out,
  output logic [WIDTH-1:0]   count_out,
  output logic               last_out,
  output logic               busy_out,
  output logic               done_out,
  output logic [TALLY_W-1:0] tally_out
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_count;
  logic [WIDTH-1:0]   r_start;
  logic [WIDTH-1:0]   r_end;
  logic [WIDTH-1:0]   r_step;
  logic               r_wrap;
  logic [TALLY_W-1:0] r_tally;

  logic [WIDTH-1:0]   w_step_eff;
  logic [WIDTH:0]     w_next;
  logic               w_last;
  logic               w_xfer;
  logic               w_launch;

  // The extra carry bit makes an overflowing step count as "past the bound".
  assign w_step_eff = (r_step == '0) ? WIDTH'(1) : r_step;
  assign w_next     = {1'b0, r_count} + {1'b0, w_step_eff};
  assign w_last     = (r_state == S_RUN) && (w_next >= {1'b0, r_end});
  assign w_xfer     = (r_state == S_RUN) && read_in && !abort_in;
  assign w_launch   = (r_state != S_RUN) && start_in;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    valid_out    = 1'b0;
    busy_out     = 1'b0;
    done_out     = 1'b0;
    last_out     = w_last;
    count_out    = r_count;
    tally_out    = r_tally;
    case (r_state)
      S_IDLE, S_DONE: begin
        done_out = (r_state == S_DONE);
        if (start_in) begin
          w_state_next = (start_val_in < end_val_in) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        valid_out = 1'b1;
        busy_out  = 1'b1;
        if (abort_in) begin
          w_state_next = S_DONE;
        end else if (w_xfer && w_last && !r_wrap) begin
          w_state_next = S_DONE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
      r_start <= '0;
      r_end   <= '0;
      r_step  <= '0;
      r_wrap  <= 1'b0;
      r_tally <= '0;
    end else if (w_launch) begin
      r_count <= start_val_in;
      r_start <= start_val_in;
      r_end   <= end_val_in;
      r_step  <= step_in;
      r_wrap  <= wrap_in;
      r_tally <= '0;
    end else if (w_xfer) begin
      if (r_tally != '1) begin
        r_tally <= r_tally + TALLY_W'(1);
      end
      // A one-shot final transfer leaves the counter on the last value emitted.
      if (!w_last) begin
        r_count <= w_next[WIDTH-1:0];
      end else if (r_wrap) begin
        r_count <= r_start;
      end
    end
  end

endmodule

// File: tb/tb_stream_counter.sv
// Bench for stream_counter (8-bit counts, 4-bit tally): directed sequences pinned with
// literal expectations, then randomized traffic checked every cycle against a model.
module tb_stream_counter;

  localparam int W  = 8;
  localparam int TW = 4;
  localparam int TALLY_MAX = (1 << TW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  start_val_in = '0;
  logic [W-1:0]  end_val_in = '0;
  logic [W-1:0]  step_in = '0;
  logic          wrap_in = 1'b0;
  logic          start_in = 1'b0;
  logic          abort_in = 1'b0;
  logic          read_in = 1'b0;
  logic          valid_out;
  logic [W-1:0]  count_out;
  logic          last_out;
  logic          busy_out;
  logic          done_out;
  logic [TW-1:0] tally_out;

  int checks = 0;
  int errors = 0;

  stream_counter #(.WIDTH(W), .TALLY_W(TW)) dut (
    .clk(clk), .rst(rst),
    .start_val_in(start_val_in), .end_val_in(end_val_in), .step_in(step_in),
    .wrap_in(wrap_in), .start_in(start_in), .abort_in(abort_in), .read_in(read_in),
    .valid_out(valid_out), .count_out(count_out), .last_out(last_out),
    .busy_out(busy_out), .done_out(done_out), .tally_out(tally_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: plain integers, a sequence is "running" or "finished".
  bit m_run = 1'b0;
  bit m_done = 1'b0;
  bit m_wrap = 1'b0;
  int m_cnt = 0, m_tally = 0, m_s = 0, m_e = 0, m_st = 0;

  function automatic int eff_step();
    return (m_st == 0) ? 1 : m_st;
  endfunction

  function automatic bit m_last();
    return m_run && ((m_cnt + eff_step()) >= m_e);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_run = 0; m_done = 0; m_wrap = 0;
      m_cnt = 0; m_tally = 0; m_s = 0; m_e = 0; m_st = 0;
    end else if (!m_run) begin
      if (start_in) begin
        m_s = start_val_in; m_e = end_val_in; m_st = step_in; m_wrap = wrap_in;
        m_cnt = start_val_in; m_tally = 0;
        m_run = (m_s < m_e);
        m_done = !m_run;
      end
    end else if (abort_in) begin
      m_run = 0; m_done = 1;
    end else if (read_in) begin
      if (m_tally < TALLY_MAX) m_tally++;
      if (m_last()) begin
        if (m_wrap) m_cnt = m_s;
        else begin m_run = 0; m_done = 1; end
      end else begin
        m_cnt = m_cnt + eff_step();
      end
    end
  end

  // Transfer log used by the directed tests.
  int log_c[$];
  int log_l[$];
  int exp_c[$];
  int exp_l[$];

  always @(negedge clk) begin
    chk("valid", valid_out, m_run);
    chk("busy", busy_out, m_run);
    chk("done", done_out, m_done);
    chk("last", last_out, m_last());
    chk("count", count_out, m_cnt);
    chk("tally", tally_out, m_tally);
    if (valid_out && read_in && !abort_in) begin
      log_c.push_back(count_out);
      log_l.push_back(last_out);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic launch(input int s, input int e, input int st, input bit w);
    start_val_in = W'(s); end_val_in = W'(e); step_in = W'(st); wrap_in = w;
    start_in = 1'b1;
    log_c.delete(); log_l.delete();
    tick();
    start_in = 1'b0;
    start_val_in = '1; end_val_in = '0; step_in = 8'd77; wrap_in = !w;
  endtask

  task automatic end_run();
    read_in = 1'b0; abort_in = 1'b1;
    tick();
    abort_in = 1'b0;
  endtask

  task automatic chk_log(input string nm);
    chk({nm, " len"}, log_c.size(), exp_c.size());
    for (int i = 0; i < log_c.size() && i < exp_c.size(); i++) begin
      chk($sformatf("%s cnt[%0d]", nm, i), log_c[i], exp_c[i]);
      chk($sformatf("%s last[%0d]", nm, i), log_l[i], exp_l[i]);
    end
  endtask

  initial begin
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("rst valid", valid_out, 0);
    chk("rst done", done_out, 0);
    chk("rst count", count_out, 0);
    chk("rst tally", tally_out, 0);

    // One-shot 0..10 step 3
    launch(0, 10, 3, 0);
    read_in = 1'b1;
    repeat (6) tick();
    read_in = 1'b0;
    exp_c = {0, 3, 6, 9}; exp_l = {0, 0, 0, 1};
    chk_log("oneshot");
    chk("oneshot done", done_out, 1);
    chk("oneshot tally", tally_out, 4);
    chk("oneshot count", count_out, 9);

    // Wrap 2..6 step 2, 7 reads
    launch(2, 6, 2, 1);
    read_in = 1'b1;
    repeat (7) tick();
    read_in = 1'b0;
    exp_c = {2, 4, 2, 4, 2, 4, 2}; exp_l = {0, 1, 0, 1, 0, 1, 0};
    chk_log("wrap");
    chk("wrap busy", busy_out, 1);
    chk("wrap tally", tally_out, 7);
    chk("wrap count", count_out, 4);
    end_run();

    // Backpressure 1,0,0,1
    launch(10, 50, 5, 0);
    read_in = 1'b1; tick();
    read_in = 1'b0; tick();
    chk("bp hold", count_out, 15);
    tick();
    read_in = 1'b1; tick();
    read_in = 1'b0;
    exp_c = {10, 15}; exp_l = {0, 0};
    chk_log("bp");
    chk("bp count", count_out, 20);
    end_run();

    // Overflow via carry
    launch(250, 255, 4, 0);
    read_in = 1'b1;
    repeat (4) tick();
    read_in = 1'b0;
    exp_c = {250, 254}; exp_l = {0, 1};
    chk_log("ovf");
    chk("ovf done", done_out, 1);
    chk("ovf count", count_out, 254);

    // Empty sequence, then step 0
    launch(5, 5, 1, 0);
    chk("empty done", done_out, 1);
    chk("empty busy", busy_out, 0);
    chk("empty tally", tally_out, 0);
    launch(3, 6, 0, 0);
    read_in = 1'b1;
    repeat (5) tick();
    read_in = 1'b0;
    exp_c = {3, 4, 5}; exp_l = {0, 0, 1};
    chk_log("step0");

    // Abort beats read
    launch(0, 100, 1, 0);
    read_in = 1'b1;
    repeat (2) tick();
    abort_in = 1'b1;
    tick();
    abort_in = 1'b0; read_in = 1'b0;
    chk("abort done", done_out, 1);
    chk("abort tally", tally_out, 2);
    chk("abort count", count_out, 2);

    // Tally saturation in long wrap run
    launch(0, 3, 1, 1);
    read_in = 1'b1;
    repeat (20) tick();
    chk("sat tally", tally_out, TALLY_MAX);

    // Reset mid-run
    rst = 1'b0;
    #1;
    chk("arst valid", valid_out, 0);
    chk("arst last", last_out, 0);
    chk("arst busy", busy_out, 0);
    chk("arst count", count_out, 0);
    chk("arst tally", tally_out, 0);
    read_in = 1'b0;
    tick();
    rst = 1'b1;
    repeat (3) tick();
    chk("post rst busy", busy_out, 0);
    chk("post rst done", done_out, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      read_in = 1'($urandom_range(0, 1));
      abort_in = ($urandom_range(0, 15) == 0);
      start_in = ($urandom_range(0, 7) == 0);
      wrap_in = 1'($urandom_range(0, 1));
      start_val_in = W'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) end_val_in = W'($urandom_range(0, 255));
      else end_val_in = W'(start_val_in + W'($urandom_range(0, 20)));
      case ($urandom_range(0, 3))
        0: step_in = '0;
        1: step_in = W'($urandom_range(1, 255));
        default: step_in = W'($urandom_range(1, 6));
      endcase
      if (!rst) rst = 1'b1;
      else if ($urandom_range(0, 199) == 0) rst = 1'b0;
      tick();
    end
    rst = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
